muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the RV64 single-cycle core. It implements the full RV64M set: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, plus the W-suffixed word forms. It replaces the combinational multiplier in the ALU path. The core asserts start when it decodes an M-extension instruction and stalls the PC and register-file write while busy is high. The result is written back when done pulses.

---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one iteration per cycle, fixed latency for every operation.
module muldiv_unit #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 7
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        op,
    input  logic              word,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam int unsigned HW = (DATA_W == 64) ? 32 : DATA_W;
    localparam int unsigned SH = DATA_W - HW;
    localparam logic [CNT_W-1:0] LastIter = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] sext_word(input logic [DATA_W-1:0] x);
        logic signed [DATA_W-1:0] t;
        t = signed'(x << SH);
        return DATA_W'(t >>> SH);
    endfunction

    function automatic logic [DATA_W-1:0] zext_word(input logic [DATA_W-1:0] x);
        return (x << SH) >> SH;
    endfunction

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic [2:0]          op_q, op_d;
    logic                word_q, word_d;
    logic                neg_q, neg_d;
    logic                special_q, special_d;
    logic [DATA_W-1:0]   special_val_q, special_val_d;
    logic [DATA_W-1:0]   result_q, result_d;

    // Operand conditioning at latch time
    logic              word_mode, signed_a, signed_b, sa, sb, is_div;
    logic              div_zero, div_ovf, mul_undef;
    logic [DATA_W-1:0] a_ext, b_ext, a_mag, b_mag, min_n;

    always_comb begin
        word_mode = (DATA_W == 64) && word;
        signed_a  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        signed_b  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_ext     = operand_a;
        b_ext     = operand_b;
        if (word_mode) begin
            a_ext = signed_a ? sext_word(operand_a) : zext_word(operand_a);
            b_ext = signed_b ? sext_word(operand_b) : zext_word(operand_b);
        end
        sa        = signed_a && a_ext[DATA_W-1];
        sb        = signed_b && b_ext[DATA_W-1];
        a_mag     = sa ? -a_ext : a_ext;
        b_mag     = sb ? -b_ext : b_ext;
        is_div    = op[2];
        min_n     = word_mode ? ({DATA_W{1'b1}} << (HW - 1)) : ({DATA_W{1'b1}} << (DATA_W - 1));
        div_zero  = is_div && (b_ext == '0);
        div_ovf   = is_div && !op[0] && (a_ext == min_n) && (b_ext == '1);
        mul_undef = !is_div && word_mode && (op[1:0] != 2'b00);
    end

    // One iteration of the datapath
    logic [DATA_W:0]     mul_sum, rem_sh, div_diff;
    logic [2*DATA_W-1:0] mul_next, div_next, acc_step, prod;
    logic [DATA_W-1:0]   mul_val, div_raw, div_val, raw_val, final_val;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[DATA_W-1:1]};
        rem_sh   = acc_q[2*DATA_W-1:DATA_W-1];
        div_diff = rem_sh - {1'b0, opnd_q};
        div_next = {div_diff[DATA_W] ? rem_sh[DATA_W-1:0] : div_diff[DATA_W-1:0],
                    acc_q[DATA_W-2:0], ~div_diff[DATA_W]};
        acc_step = op_q[2] ? div_next : mul_next;

        prod      = neg_q ? -acc_step : acc_step;
        mul_val   = (op_q[1:0] == 2'b00) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
        div_raw   = op_q[1] ? acc_step[2*DATA_W-1:DATA_W] : acc_step[DATA_W-1:0];
        div_val   = neg_q ? -div_raw : div_raw;
        raw_val   = special_q ? special_val_q : (op_q[2] ? div_val : mul_val);
        final_val = word_q ? sext_word(raw_val) : raw_val;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        opnd_d        = opnd_q;
        op_d          = op_q;
        word_d        = word_q;
        neg_d         = neg_q;
        special_d     = special_q;
        special_val_d = special_val_q;
        result_d      = result_q;
        if (abort) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d   = StBusy;
                        cnt_d     = '0;
                        op_d      = op;
                        word_d    = word_mode;
                        // Remainder follows the dividend; everything else follows sa ^ sb
                        neg_d     = (is_div && op[1]) ? sa : (sa ^ sb);
                        opnd_d    = is_div ? b_mag : a_mag;
                        acc_d     = {{DATA_W{1'b0}}, is_div ? a_mag : b_mag};
                        special_d = div_zero || div_ovf || mul_undef;
                        if (div_zero) begin
                            special_val_d = op[1] ? a_ext : '1;
                        end else if (div_ovf) begin
                            special_val_d = op[1] ? '0 : a_ext;
                        end else begin
                            special_val_d = '0;
                        end
                    end
                end
                StBusy: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastIter) begin
                        state_d  = StDone;
                        result_d = final_val;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            acc_q         <= '0;
            opnd_q        <= '0;
            op_q          <= '0;
            word_q        <= 1'b0;
            neg_q         <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            opnd_q        <= opnd_d;
            op_q          <= op_d;
            word_q        <= word_d;
            neg_q         <= neg_d;
            special_q     <= special_d;
            special_val_q <= special_val_d;
            result_q      <= result_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with DATA_W=64.
module tb_muldiv_unit;

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;
    localparam logic [2:0] OpRem    = 3'b110;
    localparam logic [2:0] OpRemu   = 3'b111;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        word = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [63:0] operand_a = '0;
    logic [63:0] operand_b = '0;
    logic        busy, done;
    logic [63:0] result;

    int checks = 0;
    int failures = 0;
    int lat, bcnt, dcnt;

    muldiv_unit #(.DATA_W(64), .CNT_W(7)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .start     (start),
        .abort     (abort),
        .op        (op),
        .word      (word),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at the first negedge after the accepting edge; returns at the done sample.
    task automatic wait_done(output int l, output int bc);
        l  = 1;
        bc = 0;
        while (1) begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1 || l >= 200) break;
            @(negedge clk);
            l++;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                          input logic [63:0] b, output int l, output int bc);
        @(negedge clk);
        op = o; word = w; operand_a = a; operand_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(l, bc);
    endtask

    task automatic op_check(input string tag, input logic [2:0] o, input logic w,
                            input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        int l, bc;
        run_op(o, w, a, b, l, bc);
        check({tag, " latency"}, 64'(l), 64'd65);
        check(tag, result, exp);
    endtask

    initial begin
        #2;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", result, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;

        run_op(OpMul, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, lat, bcnt);
        check("mul latency", 64'(lat), 64'd65);
        check("mul busy cycles", 64'(bcnt), 64'd65);
        check("mul result", result, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        check("mul idle after done", 64'(busy), 64'd0);

        op_check("mulh", OpMulh, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        op_check("mulhu", OpMulhu, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'd1);
        op_check("mulhsu", OpMulhsu, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'hFFFF_FFFF_FFFF_FFFF);
        op_check("div", OpDiv, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        op_check("rem", OpRem, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        op_check("divu by zero", OpDivu, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        op_check("rem by zero", OpRem, 1'b0, 64'd5, 64'd0, 64'd5);
        op_check("div overflow", OpDiv, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000);
        op_check("rem overflow", OpRem, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'd0);
        op_check("divw overflow", OpDiv, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
                 64'hFFFF_FFFF_8000_0000);
        op_check("mulw", OpMul, 1'b1, 64'h0000_0001_0000_0003, 64'h0000_0001_0000_0005, 64'd15);
        op_check("mulhw undefined", OpMulh, 1'b1, 64'd3, 64'd5, 64'd0);
        op_check("divu", OpDivu, 1'b0, 64'd100, 64'd7, 64'd14);
        op_check("remu", OpRemu, 1'b0, 64'd100, 64'd7, 64'd2);

        // start held through a whole operation while operands toggle
        @(negedge clk);
        op = OpDivu; word = 1'b0; operand_a = 64'd100; operand_b = 64'd7; start = 1'b1;
        @(negedge clk);
        operand_a = 64'hDEAD_BEEF_0123_4567;
        operand_b = 64'd3;
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            operand_a = ~operand_a;
        end
        check("held start latency", 64'(lat), 64'd65);
        check("held start result", result, 64'd14);
        @(negedge clk);
        start = 1'b0;
        check("held start idle", 64'(busy), 64'd0);
        dcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
            if (busy === 1'b1) bcnt++;
        end
        check("held start extra done", 64'(dcnt), 64'd0);
        check("held start extra busy", 64'(bcnt), 64'd0);

        // start raised during DONE is ignored, accepted in the following IDLE cycle
        op_check("mulw again", OpMul, 1'b1, 64'h0000_0001_0000_0003, 64'h0000_0001_0000_0005,
                 64'd15);
        op = OpRemu; word = 1'b0; operand_a = 64'd100; operand_b = 64'd7; start = 1'b1;
        @(negedge clk);
        check("start in done ignored", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("start in idle accepted", 64'(busy), 64'd1);
        wait_done(lat, bcnt);
        check("restart latency", 64'(lat), 64'd65);
        check("restart result", result, 64'd2);

        // abort at iteration 10
        @(negedge clk);
        op = OpDiv; operand_a = 64'hFFFF_FFFF_FFFF_FFF9; operand_b = 64'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check("abort no done", 64'(dcnt), 64'd0);
        check("abort result kept", result, 64'd2);

        // asynchronous reset mid-operation
        @(negedge clk);
        op = OpMul; operand_a = 64'd7; operand_b = 64'hFFFF_FFFF_FFFF_FFFD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset done", 64'(done), 64'd0);
        check("async reset result", result, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        op_check("post reset div", OpDiv, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                 64'hFFFF_FFFF_FFFF_FFFD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
